simon_sequence_game: RTL and testbench
======================================

// Module: simon_sequence_game
// PURPOSE
//  Parametrised LED/button memory game: N_LEDS LEDs, N_LEDS push-buttons, sequence up to MAX_LEN.
//  Each round replays a growing pseudo-random LED sequence. The player then repeats it on the buttons.
//  Top-level game core on the board clock. Buttons arrive already debounced and synchronised.
// PARAMETERS
//  N_LEDS          4           LED/button count; power of two, 2..16
//  MAX_LEN         8           sequence length that wins the game, 1..32
//  TICKS_ON        50_000_000  cycles a LED is lit per replay step (1 s @ 50 MHz)
//  TICKS_GAP       25_000_000  dark cycles after each replay step
//  LFSR_SEED       16'hACE1    LFSR value loaded on reset; must be non-zero
//  TIMEOUT_TICKS   250_000_000 input timeout; used only with INPUT_TIMEOUT_EN
// PORTS
//  osc_clk  in   1                      board clock; the only clock
//  reset_n  in   1                      synchronous, active-high reset
//  start    in   1                      1-cycle pulse: begin new game (IDLE/WIN/FAIL only)
//  button   in   N_LEDS                 player buttons, level, 1 = pressed
//  led      out  N_LEDS                 LED drive, 1 = lit
//  round    out  $clog2(MAX_LEN+1)      current sequence length; 0 in IDLE
//  busy     out  1                      1 in GEN/SHOW_ON/SHOW_GAP/WAIT_IN
//  win      out  1                      level, 1 in WIN
//  fail     out  1                      level, 1 in FAIL
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (any state, mid-game too): state=IDLE. led/round/busy/win/fail=0. lfsr=LFSR_SEED. Counters, step, btn_q=0.
//  LFSR: 16-bit Galois, mask 16'hB400. Shifts every cycle in every state, so start timing adds entropy.
//  FSM states: IDLE, GEN, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, FAIL.
//  IDLE/WIN/FAIL --start--> GEN. start is ignored in all other states.
//  GEN: MAX_LEN cycles. seq[k] <= lfsr[$clog2(N_LEDS)-1:0], k=0..MAX_LEN-1. Then round=1, step=0, -> SHOW_ON.
//  SHOW_ON: led=onehot(seq[step]) for TICKS_ON cycles -> SHOW_GAP.
//  SHOW_GAP: led=0 for TICKS_GAP cycles. step<round-1: step++ -> SHOW_ON. Else step=0 -> WAIT_IN.
//  WAIT_IN: led=button (echo). press = button & ~btn_q (btn_q registered every cycle, all states).
//   press==0: stay. Exactly one bit set and equal to onehot(seq[step]): correct. Any other non-zero press: -> FAIL.
//   Correct and step<round-1: step++.
//   Correct and last step: round==MAX_LEN -> WIN. Else round++, step=0 -> SHOW_ON.
//  Edges during GEN/SHOW_* are discarded. btn_q still tracks, so a held button does not count as a press.
//  WIN: led = alternating 0101.. pattern; round holds MAX_LEN. FAIL: led = all ones; round holds failing round.
//  Counters: cycle count of SHOW_ON is exactly TICKS_ON, of SHOW_GAP exactly TICKS_GAP.
//  Counter width is $clog2 of the largest tick param. Counter clears on every state change.
// CONFIGURATION
//  INPUT_TIMEOUT_EN defined: in WAIT_IN, a cycle counter clears on entry and on each correct press.
//   At TIMEOUT_TICKS cycles with no press -> FAIL.
//  INPUT_TIMEOUT_EN undefined: WAIT_IN waits forever. No timeout counter is synthesised.
// STRUCTURE
//  Package game_pkg: state enum game_state_t, LFSR_MASK=16'hB400, onehot function.
//  Sub-module game_lfsr (osc_clk, reset_n, seed param, q[15:0]): free-running Galois LFSR.
//  Sequence store: MAX_LEN x $clog2(N_LEDS) register array inside the top module.
// TESTING (bench params N_LEDS=4, MAX_LEN=3, TICKS_ON=4, TICKS_GAP=2, TIMEOUT_TICKS=20)
//  Reset then idle: led=0, round=0, busy=0, win=0, fail=0. Reset asserted in SHOW_ON -> next cycle all outputs 0.
//  Start; bench LFSR model predicts seq; perfect play through 3 rounds.
//   -> replay shows 1, 2 and 3 steps, each step 4 lit + 2 dark cycles.
//   -> round 1->2->3, then win=1, led=4'b0101, busy=0.
//  Round 2: first press correct, second press wrong one-hot -> fail=1, led=4'hF, round=2.
//  WAIT_IN: two buttons rise in the same cycle -> FAIL. Button held from SHOW_GAP into WAIT_IN -> no press counted.
//  start pulse during SHOW_ON -> ignored; a start after FAIL -> GEN, new sequence, round=1.
//  With INPUT_TIMEOUT_EN: no press for 20 cycles in WAIT_IN -> fail=1. Without it: 1000 idle cycles -> still busy=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the Simon sequence game core.
package game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_SHOW_ON,
      S_SHOW_GAP,
      S_WAIT_IN,
      S_WIN,
      S_FAIL
   } game_state_t;

   localparam logic [15:0] LFSR_MASK   = 16'hB400;
   localparam logic [15:0] ALT_PATTERN = 16'h5555;

   function automatic logic [15:0] onehot(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Galois LFSR; shifts every cycle, reloads SEED on reset.
module game_lfsr
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        osc_clk,
   input  logic        reset_n,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge osc_clk) begin
      if (reset_n) lfsr_q <= SEED;
      else         lfsr_q <= lfsr_next(lfsr_q);
   end

   assign q = lfsr_q;

endmodule

// File: rtl/simon_sequence_game.sv
// Simon-style LED/button memory game core (single clock, synchronous active-high reset).
// Optional input timeout in WAIT_IN is enabled by defining INPUT_TIMEOUT_EN.
module simon_sequence_game
   import game_pkg::*;
#(
   parameter int          N_LEDS        = 4,
   parameter int          MAX_LEN       = 8,
   parameter int          TICKS_ON      = 50_000_000,
   parameter int          TICKS_GAP     = 25_000_000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          TIMEOUT_TICKS = 250_000_000
) (
   input  logic                         osc_clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [N_LEDS-1:0]            button,
   output logic [N_LEDS-1:0]            led,
   output logic [$clog2(MAX_LEN+1)-1:0] round,
   output logic                         busy,
   output logic                         win,
   output logic                         fail
);

   localparam int IDX_W    = $clog2(N_LEDS);
   localparam int STEP_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int RND_W    = $clog2(MAX_LEN + 1);
   localparam int TICK_MAX = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
   localparam int CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

   localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(TICKS_ON - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(TICKS_GAP - 1);
   localparam logic [STEP_W-1:0] GEN_LAST = STEP_W'(MAX_LEN - 1);
   localparam logic [RND_W-1:0]  RND_MAX  = RND_W'(MAX_LEN);

   game_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [RND_W-1:0]  round_q, round_d;
   logic [N_LEDS-1:0] btn_q;
   logic [IDX_W-1:0]  seq_q [MAX_LEN];

   logic [15:0]       lfsr_val;
   logic [N_LEDS-1:0] press;
   logic [N_LEDS-1:0] target;
   logic              last_step;
   logic              unused_lfsr;

`ifdef INPUT_TIMEOUT_EN
   localparam int             TO_W    = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
   logic [TO_W-1:0] to_q, to_d;
`endif

   game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .osc_clk (osc_clk),
      .reset_n (reset_n),
      .q       (lfsr_val)
   );

   // Only the low index bits feed the sequence; the rest of the LFSR is pure state.
   assign unused_lfsr = ^lfsr_val[15:IDX_W];

   assign press     = button & ~btn_q;
   assign target    = N_LEDS'(onehot(4'(seq_q[step_q])));
   assign last_step = (RND_W'(step_q) + RND_W'(1)) == round_q;

   always_ff @(posedge osc_clk) begin
      if (reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         round_q <= '0;
         btn_q   <= '0;
`ifdef INPUT_TIMEOUT_EN
         to_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         round_q <= round_d;
         btn_q   <= button;
`ifdef INPUT_TIMEOUT_EN
         to_q    <= to_d;
`endif
      end
   end

   // NOTE: the sequence store is deliberately not reset; GEN rewrites every entry before replay reads it.
   always_ff @(posedge osc_clk) begin
      if (state_q == S_GEN) seq_q[step_q] <= lfsr_val[IDX_W-1:0];
   end

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      step_d  = step_q;
      round_d = round_q;
`ifdef INPUT_TIMEOUT_EN
      to_d    = '0;
`endif
      unique case (state_q)
         S_IDLE, S_WIN, S_FAIL: begin
            if (start) begin
               state_d = S_GEN;
               step_d  = '0;
               round_d = '0;
            end
         end
         S_GEN: begin
            if (step_q == GEN_LAST) begin
               state_d = S_SHOW_ON;
               step_d  = '0;
               round_d = RND_W'(1);
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         S_SHOW_ON: begin
            if (cnt_q == ON_LAST) state_d = S_SHOW_GAP;
            else                  cnt_d   = cnt_q + 1'b1;
         end
         S_SHOW_GAP: begin
            if (cnt_q != GAP_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (last_step) begin
               step_d  = '0;
               state_d = S_WAIT_IN;
            end else begin
               step_d  = step_q + 1'b1;
               state_d = S_SHOW_ON;
            end
         end
         S_WAIT_IN: begin
            if (press == '0) begin
`ifdef INPUT_TIMEOUT_EN
               if (to_q == TO_LAST) state_d = S_FAIL;
               else                 to_d    = to_q + 1'b1;
`endif
            end else if (press == target) begin
               if (!last_step) begin
                  step_d = step_q + 1'b1;
               end else if (round_q == RND_MAX) begin
                  state_d = S_WIN;
               end else begin
                  round_d = round_q + 1'b1;
                  step_d  = '0;
                  state_d = S_SHOW_ON;
               end
            end else begin
               state_d = S_FAIL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      unique case (state_q)
         S_SHOW_ON: led = target;
         S_WAIT_IN: led = button;
         S_WIN:     led = N_LEDS'(ALT_PATTERN);
         S_FAIL:    led = '1;
         default:   led = '0;
      endcase
   end

   assign round = round_q;
   assign busy  = state_q inside {S_GEN, S_SHOW_ON, S_SHOW_GAP, S_WAIT_IN};
   assign win   = (state_q == S_WIN);
   assign fail  = (state_q == S_FAIL);

endmodule

// File: tb/tb_simon_sequence_game.sv
// Directed bench for simon_sequence_game: scripted per-cycle expectations from the game rules,
// sequence predicted by an independent LFSR model; covers INPUT_TIMEOUT_EN when defined.
module tb_simon_sequence_game;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [3:0] button;
   logic [3:0] led;
   logic [1:0] round;
   logic       busy;
   logic       win;
   logic       fail;

   int checks = 0;
   int errors = 0;

   logic       chk_en = 1'b0;
   logic [3:0] exp_led;
   logic [1:0] exp_round;
   logic       exp_round_vld;
   logic       exp_busy;
   logic       exp_win;
   logic       exp_fail;

   logic [15:0] m_lfsr;
   logic [1:0]  seq [3];

   simon_sequence_game #(
      .N_LEDS        (4),
      .MAX_LEN       (3),
      .TICKS_ON      (4),
      .TICKS_GAP     (2),
      .LFSR_SEED     (16'hACE1),
      .TIMEOUT_TICKS (20)
   ) dut (
      .osc_clk (clk),
      .reset_n (reset_n),
      .start   (start),
      .button  (button),
      .led     (led),
      .round   (round),
      .busy    (busy),
      .win     (win),
      .fail    (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: right-shifting Galois register, reloaded while reset is high.
   always @(posedge clk) begin
      if (reset_n) m_lfsr <= 16'hACE1;
      else         m_lfsr <= (m_lfsr >> 1) ^ ({16{m_lfsr[0]}} & 16'hB400);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("led", 32'(led), 32'(exp_led));
         check("busy", 32'(busy), 32'(exp_busy));
         check("win", 32'(win), 32'(exp_win));
         check("fail", 32'(fail), 32'(exp_fail));
         if (exp_round_vld) check("round", 32'(round), 32'(exp_round));
      end
   end

   function automatic logic [3:0] oh(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Describe the outputs expected in the current cycle, then advance one cycle.
   task automatic cyc(input logic [3:0] e_led, input int e_round,
                      input logic e_busy, input logic e_win, input logic e_fail);
      exp_led       = e_led;
      exp_round_vld = (e_round >= 0);
      exp_round     = e_round[1:0];
      exp_busy      = e_busy;
      exp_win       = e_win;
      exp_fail      = e_fail;
      chk_en        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic gen();
      for (int k = 0; k < 3; k++) begin
         seq[k] = m_lfsr[1:0];
         cyc(4'b0000, -1, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic replay(input int r);
      for (int s = 0; s < r; s++) begin
         repeat (4) cyc(oh(seq[s]), r, 1'b1, 1'b0, 1'b0);
         repeat (2) cyc(4'b0000, r, 1'b1, 1'b0, 1'b0);
      end
   endtask

   // Replay round r, then press the sequence back; step wrong_at gets a wrong button.
   task automatic play_round(input int r, input int wrong_at);
      logic [3:0] b;
      replay(r);
      for (int s = 0; s < r; s++) begin
         b = (s == wrong_at) ? oh(seq[s] + 2'd1) : oh(seq[s]);
         button = b;
         cyc(b, r, 1'b1, 1'b0, 1'b0);
         button = 4'b0000;
         if (s == wrong_at) return;
         if (s < r - 1) cyc(4'b0000, r, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [3:0] wrong;
      reset_n = 1'b1;
      start   = 1'b0;
      button  = 4'b0000;
      @(posedge clk);
      #1;

      // Reset and idle; start lands when the LFSR has stepped four times past the seed.
      repeat (2) cyc(4'b0000, 0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      repeat (4) cyc(4'b0000, 0, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      cyc(4'b0000, 0, 1'b0, 1'b0, 1'b0);
      gen();
      check("pin_seq", 32'({seq[0], seq[1], seq[2]}), 32'h3D);
      check("pin_first_led", 32'(led), 32'h8);

      // Game 1: perfect play to a win.
      play_round(1, -1);
      play_round(2, -1);
      play_round(3, -1);
      check("pin_win_led", 32'(led), 32'h5);
      repeat (2) cyc(4'b0101, 3, 1'b0, 1'b1, 1'b0);

      // Game 2 from WIN: wrong second press in round 2.
      start = 1'b1;
      cyc(4'b0101, 3, 1'b0, 1'b1, 1'b0);
      gen();
      play_round(1, -1);
      play_round(2, 1);
      check("pin_fail_round", 32'(round), 32'h2);
      repeat (2) cyc(4'b1111, 2, 1'b0, 1'b0, 1'b1);

      // Game 3: start ignored in SHOW_ON, held button not a press, double press fails.
      start = 1'b1;
      cyc(4'b1111, 2, 1'b0, 1'b0, 1'b1);
      gen();
      wrong = oh(seq[0] + 2'd1);
      cyc(oh(seq[0]), 1, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      repeat (3) cyc(oh(seq[0]), 1, 1'b1, 1'b0, 1'b0);
      button = wrong;
      repeat (2) cyc(4'b0000, 1, 1'b1, 1'b0, 1'b0);
      cyc(wrong, 1, 1'b1, 1'b0, 1'b0);
      button = 4'b0000;
      cyc(4'b0000, 1, 1'b1, 1'b0, 1'b0);
      button = oh(seq[0]) | wrong;
      cyc(oh(seq[0]) | wrong, 1, 1'b1, 1'b0, 1'b0);
      button = 4'b0000;
      cyc(4'b1111, 1, 1'b0, 1'b0, 1'b1);

      // Game 4: reset asserted during SHOW_ON.
      start = 1'b1;
      cyc(4'b1111, 1, 1'b0, 1'b0, 1'b1);
      gen();
      cyc(oh(seq[0]), 1, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc(oh(seq[0]), 1, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b0;
      repeat (3) cyc(4'b0000, 0, 1'b0, 1'b0, 1'b0);

      // Game 5: no input at all in WAIT_IN.
      start = 1'b1;
      cyc(4'b0000, 0, 1'b0, 1'b0, 1'b0);
      gen();
      replay(1);
`ifdef INPUT_TIMEOUT_EN
      repeat (20) cyc(4'b0000, 1, 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(4'b1111, 1, 1'b0, 1'b0, 1'b1);
`else
      repeat (1000) cyc(4'b0000, 1, 1'b1, 1'b0, 1'b0);
`endif

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
